// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles 32-bit words from a byte-wide,
// shared memory port and presents them to the IF/ID register.
module if_fetch #(
    parameter logic [16:0] RESET_PC = 17'h00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        hold,
    input  logic        redirect,
    input  logic [16:0] redirect_pc,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [16:0] mem_addr,
    output logic        if_valid,
    output logic [16:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fetch_busy
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [16:0] pc;
    logic [16:0] pc_n;
    logic [2:0]  icnt;
    logic [2:0]  icnt_n;
    logic [1:0]  bcnt;
    logic [1:0]  bcnt_n;
    logic        pend;
    logic        pend_n;
    logic [31:0] word_q;
    logic [31:0] word_n;
    logic        valid_n;
    logic [16:0] ipc_n;
    logic [31:0] inst_n;
    logic        issue;

    // Byte requests go out only while fetching with bytes left to issue;
    // reset and a global stall both silence the port.
    always_comb begin
        mem_req    = rst & rdy & (state == FETCH) & (icnt < 3'd4);
        mem_addr   = pc + {14'b0, icnt};
        issue      = mem_req & mem_grant;
        fetch_busy = rst & (state == FETCH);
    end

    // Next-state logic: byte capture, word hand-off and redirect, with
    // redirect applied last so it overrides a same-cycle hand-off.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        icnt_n  = icnt;
        bcnt_n  = bcnt;
        pend_n  = pend;
        word_n  = word_q;
        valid_n = if_valid;
        ipc_n   = if_pc;
        inst_n  = if_inst;
        if (rdy) begin
            pend_n = issue;
            if (issue) begin
                icnt_n = icnt + 3'd1;
            end
            if (pend) begin
                word_n[{bcnt, 3'b000} +: 8] = mem_din;
                bcnt_n = bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                    inst_n  = {mem_din, word_q[23:0]};
                    ipc_n   = pc;
                end
            end
            if (state == HOLD && !hold) begin
                pc_n    = pc + 17'd4;
                icnt_n  = 3'd0;
                bcnt_n  = 2'd0;
                state_n = FETCH;
                valid_n = 1'b0;
                inst_n  = 32'h0;
            end
            if (redirect) begin
                pc_n    = redirect_pc & ~17'h1;
                icnt_n  = 3'd0;
                bcnt_n  = 2'd0;
                pend_n  = 1'b0;
                state_n = FETCH;
                valid_n = 1'b0;
                inst_n  = 32'h0;
            end
        end
    end

    // State register; reset discards any partially assembled word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            icnt     <= 3'd0;
            bcnt     <= 2'd0;
            pend     <= 1'b0;
            word_q   <= 32'h0;
            if_valid <= 1'b0;
            if_pc    <= 17'h0;
            if_inst  <= 32'h0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            icnt     <= icnt_n;
            bcnt     <= bcnt_n;
            pend     <= pend_n;
            word_q   <= word_n;
            if_valid <= valid_n;
            if_pc    <= ipc_n;
            if_inst  <= inst_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte memory, transaction-level
// model with a per-cycle compare, plus hand-computed directed checks.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        hold;
    logic        redirect;
    logic [16:0] redirect_pc;
    logic        mem_grant;
    logic [7:0]  mem_din;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        if_valid;
    logic [16:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_busy;

    if_fetch #(.RESET_PC(17'h00000)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .hold(hold),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_grant(mem_grant),
        .mem_din(mem_din),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_inst(if_inst),
        .fetch_busy(fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:131071];
    logic [7:0] rdata;

    // stimulus shadows, applied at the next falling edge
    logic        t_rst, t_rdy, t_hold, t_redir, t_grant;
    logic [16:0] t_rpc;

    // sampled outputs of the most recent cycle
    logic        s_req, s_valid, s_busy;
    logic [16:0] s_addr, s_pc;
    logic [31:0] s_inst;

    int vectors = 0;
    int miscompares = 0;

    // model: word being gathered as a queue of bytes
    bit          m_known = 0;
    bit          m_pres;
    logic [16:0] m_pc;
    int          m_iss;
    logic [7:0]  m_b[$];
    bit          m_infl;
    logic [16:0] m_infl_addr;
    bit          m_valid;
    logic [16:0] m_ipc;
    logic [31:0] m_inst;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        logic        e_req;
        logic        e_busy;
        logic [16:0] e_addr;
        bit          old_pres;
        bit          issue;
        @(negedge clk);
        rst         = t_rst;
        rdy         = t_rdy;
        hold        = t_hold;
        redirect    = t_redir;
        redirect_pc = t_rpc;
        mem_grant   = t_grant;
        mem_din     = rdata;
        #1;
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = if_valid;
        s_pc    = if_pc;
        s_inst  = if_inst;
        s_busy  = fetch_busy;
        e_req  = t_rst && t_rdy && !m_pres && (m_iss < 4);
        e_busy = t_rst && !m_pres;
        e_addr = m_pc + 17'(m_iss);
        if (!t_rst || m_known) begin
            chk("mem_req", 32'(s_req), 32'(e_req));
            chk("fetch_busy", 32'(s_busy), 32'(e_busy));
        end
        if (m_known) begin
            if (e_req) chk("mem_addr", 32'(s_addr), 32'(e_addr));
            chk("if_valid", 32'(s_valid), 32'(m_valid));
            chk("if_pc", 32'(s_pc), 32'(m_ipc));
            chk("if_inst", s_inst, m_inst);
        end
        if (mem_req && mem_grant) rdata = mem[mem_addr];
        if (!t_rst) begin
            m_known = 1;
            m_pres  = 0;
            m_pc    = 17'h00000;
            m_iss   = 0;
            m_b.delete();
            m_infl  = 0;
            m_valid = 0;
            m_ipc   = 17'h0;
            m_inst  = 32'h0;
        end else if (t_rdy) begin
            old_pres = m_pres;
            issue    = e_req && t_grant;
            if (m_infl) begin
                m_b.push_back(mem[m_infl_addr]);
                if (m_b.size() == 4) begin
                    m_pres  = 1;
                    m_valid = 1;
                    m_inst  = {m_b[3], m_b[2], m_b[1], m_b[0]};
                    m_ipc   = m_pc;
                end
            end
            if (old_pres && !t_hold) begin
                m_pc    = m_pc + 17'd4;
                m_iss   = 0;
                m_b.delete();
                m_pres  = 0;
                m_valid = 0;
                m_inst  = 32'h0;
            end
            m_infl = issue;
            if (issue) begin
                m_infl_addr = e_addr;
                m_iss++;
            end
            if (t_redir) begin
                m_pc    = t_rpc & ~17'h1;
                m_iss   = 0;
                m_b.delete();
                m_infl  = 0;
                m_pres  = 0;
                m_valid = 0;
                m_inst  = 32'h0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        t_rst = 0;
        repeat (n) cyc();
        t_rst   = 1;
        t_redir = 0;
        t_rdy   = 1;
        t_hold  = 1;
        t_grant = 1;
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'(i * 37 + (i >> 8) + 11);
        mem[0] = 8'h13;
        mem[1] = 8'h05;
        mem[2] = 8'hA0;
        mem[3] = 8'h00;
        rdata = 8'h00;
        rst = 0; rdy = 1; hold = 1; redirect = 0;
        redirect_pc = 17'h0; mem_grant = 1; mem_din = 8'h00;
        t_rst = 0; t_rdy = 1; t_hold = 1; t_redir = 0;
        t_rpc = 17'h0; t_grant = 1;

        // basic fetch, hold, accept
        do_reset(2);
        for (int c = 1; c <= 12; c++) begin
            t_hold = (c != 9);
            cyc();
            if (c == 1) begin
                chk("rst_if_valid", 32'(s_valid), 32'h0);
                chk("rst_if_inst", s_inst, 32'h0);
                chk("rst_if_pc", 32'(s_pc), 32'h0);
                chk("first_req", 32'(s_req), 32'h1);
                chk("first_addr", 32'(s_addr), 32'h0);
            end
            if (c == 4) chk("addr_c4", 32'(s_addr), 32'h3);
            if (c == 5) chk("valid_c5", 32'(s_valid), 32'h0);
            if (c == 6) begin
                chk("valid_c6", 32'(s_valid), 32'h1);
                chk("inst_c6", s_inst, 32'h00A00513);
                chk("pc_c6", 32'(s_pc), 32'h0);
            end
            if (c == 8) begin
                chk("hold_req", 32'(s_req), 32'h0);
                chk("hold_inst", s_inst, 32'h00A00513);
            end
            if (c == 10) chk("next_addr", 32'(s_addr), 32'h4);
        end

        // reset mid-fetch, dominating a redirect
        t_redir = 1;
        t_rpc   = 17'h0ABCD;
        do_reset(1);

        // one-cycle grant loss
        for (int c = 1; c <= 8; c++) begin
            t_grant = (c != 3);
            t_hold  = (c != 8);
            cyc();
            if (c == 1) chk("rst_mid_addr", 32'(s_addr), 32'h0);
            if (c == 3) chk("nogrant_addr", 32'(s_addr), 32'h2);
            if (c == 4) chk("regrant_addr", 32'(s_addr), 32'h2);
            if (c == 6) chk("ng_valid_c6", 32'(s_valid), 32'h0);
            if (c == 7) begin
                chk("ng_valid_c7", 32'(s_valid), 32'h1);
                chk("ng_inst_c7", s_inst, 32'h00A00513);
            end
        end

        // redirect mid-word, then redirect+accept to the wrap point
        do_reset(1);
        for (int c = 1; c <= 19; c++) begin
            t_redir = (c == 3) || (c == 10);
            t_rpc   = (c == 3) ? 17'h01235 : 17'h1FFFE;
            t_hold  = !((c == 10) || (c == 17));
            cyc();
            if (c == 4) chk("redir_addr", 32'(s_addr), 32'h01234);
            if (c == 8) chk("redir_valid_c8", 32'(s_valid), 32'h0);
            if (c == 9) begin
                chk("redir_valid_c9", 32'(s_valid), 32'h1);
                chk("redir_pc", 32'(s_pc), 32'h01234);
            end
            if (c == 11) chk("wrap_a0", 32'(s_addr), 32'h1FFFE);
            if (c == 12) chk("wrap_a1", 32'(s_addr), 32'h1FFFF);
            if (c == 13) chk("wrap_a2", 32'(s_addr), 32'h00000);
            if (c == 14) chk("wrap_a3", 32'(s_addr), 32'h00001);
            if (c == 16) chk("wrap_pc", 32'(s_pc), 32'h1FFFE);
            if (c == 18) chk("wrap_next", 32'(s_addr), 32'h00002);
        end

        // global stall mid-fetch
        do_reset(1);
        for (int c = 1; c <= 9; c++) begin
            t_rdy = !((c == 3) || (c == 4));
            cyc();
            if (c == 3) chk("stall_req3", 32'(s_req), 32'h0);
            if (c == 4) chk("stall_req4", 32'(s_req), 32'h0);
            if (c == 5) chk("stall_addr", 32'(s_addr), 32'h2);
            if (c == 7) chk("stall_valid7", 32'(s_valid), 32'h0);
            if (c == 8) begin
                chk("stall_valid8", 32'(s_valid), 32'h1);
                chk("stall_inst", s_inst, 32'h00A00513);
            end
        end

        // mixed traffic against the model
        do_reset(1);
        for (int c = 0; c < 400; c++) begin
            t_rst   = ($urandom_range(0, 59) != 0);
            t_rdy   = ($urandom_range(0, 7) != 0);
            t_grant = ($urandom_range(0, 3) != 0);
            t_hold  = ($urandom_range(0, 2) == 0);
            t_redir = ($urandom_range(0, 24) == 0);
            t_rpc   = 17'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 17'h00000, PC loaded on reset.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 rdy  input  1  global ready; 0 freezes all state.
REQ-005 hold  input  1  downstream (IF/ID register) not accepting; 1 = keep current instruction.
REQ-006 redirect  input  1  taken branch/jump from decode; flush and refetch.
REQ-007 redirect_pc  input  17  target PC for redirect.
REQ-008 mem_grant  input  1  memory port granted to fetch this cycle (0 = load/store owns it).
REQ-009 mem_din  input  8  byte read data, valid the cycle after a granted request.
REQ-010 mem_req  output  1  byte read request.
REQ-011 mem_addr  output  17  byte address of request.
REQ-012 if_valid  output  1  if_pc/if_inst hold a complete instruction.
REQ-013 if_pc  output  17  PC of presented instruction.
REQ-014 if_inst  output  32  presented instruction; 32'h0 (bubble) when if_valid=0.
REQ-015 fetch_busy  output  1  fetch in progress, requests bubble insertion downstream.

Function
REQ-016 States SHALL be FETCH and HOLD; 3-bit issue count icnt (0..4); 2-bit byte count bcnt; 1-bit pend flag (request issued last cycle).
REQ-017 In FETCH with icnt<4: mem_req=1, mem_addr=pc+icnt (17-bit, wraps mod 2^17); icnt increments only when mem_grant=1.
REQ-018 pend SHALL be set in a cycle where mem_req=1 and mem_grant=1, cleared otherwise.
REQ-019 When pend=1: mem_din written to byte bcnt of assembly register (little-endian, byte k -> bits 8k+7:8k), bcnt increments.
REQ-020 Capture of 4th byte (bcnt=3): next state HOLD, if_valid=1, if_inst=assembled word, if_pc=pc.
REQ-021 Minimum latency with continuous grant: requests cycles t..t+3, if_valid=1 from cycle t+5.
REQ-022 mem_grant=0 mid-fetch: no issue, no icnt change; already-pending byte still captured next cycle.
REQ-023 In HOLD: mem_req=0; if_valid, if_pc, if_inst stable while hold=1.
REQ-024 In HOLD with hold=0: instruction consumed; pc<=pc+4, icnt<=0, bcnt<=0, state FETCH, if_valid=0, if_inst=0 next cycle.
REQ-025 fetch_busy=1 exactly when state=FETCH.
REQ-026 redirect=1 (any state): pc<=redirect_pc, icnt<=0, bcnt<=0, pend<=0, state FETCH, if_valid<=0, if_inst<=0; in-flight byte discarded.
REQ-027 redirect and hold=0 in same HOLD cycle: redirect wins, pc = redirect_pc (not pc+4).
REQ-028 redirect_pc bit 0 SHALL be forced to 0 on load.
REQ-029 rdy=0: all registers hold, mem_req=0; pend keeps value and captures when rdy returns.
REQ-030 No combinational path from mem_din to any output.

Reset
REQ-031 rst=0 at clk edge: pc=RESET_PC, state FETCH, icnt=0, bcnt=0, pend=0, if_valid=0, if_pc=0, if_inst=0.
REQ-032 During rst=0: mem_req=0, fetch_busy=0; first request (addr RESET_PC) in first cycle after rst=1.
REQ-033 Reset mid-fetch or in HOLD: partial word discarded, REQ-031 values next cycle; rst dominates redirect and rdy.

Verification
REQ-034 Reset release, grant=1, memory bytes 13 05 A0 00 at 0..3 -> mem_addr 0,1,2,3 on cycles 1-4; if_valid=1 cycle 6, if_inst=32'h00A00513, if_pc=0.
REQ-035 hold=1 for 3 cycles after valid -> if_inst/if_pc unchanged, mem_req=0; hold=0 -> next fetch starts at addr 4.
REQ-036 grant=0 on cycle 3 only -> addr 2 issued on cycle 4, valid delayed by one cycle to cycle 7, word unchanged.
REQ-037 redirect=1, redirect_pc=17'h01235 during byte 2 -> next mem_addr 17'h01234, old bytes discarded, if_pc=17'h01234 when valid.
REQ-038 pc=17'h1FFFE fetch -> mem_addr 1FFFE,1FFFF,00000,00001; after accept pc=17'h00002.
REQ-039 rdy=0 for 2 cycles mid-fetch -> mem_req=0, state frozen; resumed word identical to uninterrupted run.
